// File: rtl/riscv_lsu_v2.sv
// Load/store unit between the single-cycle core data port and a variable-latency memory.
// Formats byte/half/word accesses, stalls the core until completion and faults bad or hung accesses.
module riscv_lsu_v2 #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT        = 255,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_fault_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

  localparam int unsigned   CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wait_cnt, w_wait_nxt;

  logic        w_illegal, w_misalign, w_fault_cond, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rd_fmt, w_wd_rep;
  logic [3:0]  w_be;

  // Sizes 3, 6 and 7 are illegal; size[1:0] gives the access width for both signed and unsigned loads
  always_comb begin
    w_illegal = (core_size_i == 3'd3) || (core_size_i[2:1] == 2'b11);
    case (core_size_i[1:0])
      2'b01:   w_misalign = core_addr_i[0];
      2'b10:   w_misalign = |core_addr_i[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_fault_cond = w_illegal | (MISALIGN_CHECK & w_misalign);
  assign w_timeout    = (TIMEOUT != 0) && (r_wait_cnt == LAST);

  always_comb begin
    case (core_addr_i[1:0])
      2'd0:    w_byte = mem_rd_i[7:0];
      2'd1:    w_byte = mem_rd_i[15:8];
      2'd2:    w_byte = mem_rd_i[23:16];
      default: w_byte = mem_rd_i[31:24];
    endcase
    w_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (core_size_i)
      3'd0:    w_rd_fmt = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_rd_fmt = {24'd0, w_byte};
      3'd1:    w_rd_fmt = {{16{w_half[15]}}, w_half};
      3'd5:    w_rd_fmt = {16'd0, w_half};
      default: w_rd_fmt = mem_rd_i;
    endcase
  end

  always_comb begin
    case (core_size_i[1:0])
      2'b00: begin
        w_be     = 4'b0001 << core_addr_i[1:0];
        w_wd_rep = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        w_be     = 4'b0011 << {core_addr_i[1], 1'b0};
        w_wd_rep = {2{core_wd_i[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wd_rep = core_wd_i;
      end
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    mem_req_o    = 1'b0;
    core_stall_o = 1'b0;
    core_fault_o = 1'b0;
    core_rd_o    = '0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE: begin
          if (core_req_i) begin
            if (w_fault_cond) begin
              core_fault_o = 1'b1;
            end else begin
              mem_req_o    = 1'b1;
              core_stall_o = 1'b1;
              w_state_nxt  = S_BUSY;
              w_wait_nxt   = '0;
            end
          end
        end
        default: begin
          // Ready takes priority over an expiring timeout in the same cycle
          if (mem_ready_i) begin
            mem_req_o   = 1'b1;
            core_rd_o   = core_we_i ? '0 : w_rd_fmt;
            w_state_nxt = S_IDLE;
          end else if (w_timeout) begin
            core_fault_o = 1'b1;
            w_state_nxt  = S_IDLE;
          end else begin
            mem_req_o    = 1'b1;
            core_stall_o = 1'b1;
            w_wait_nxt   = r_wait_cnt + 1'b1;
          end
        end
      endcase
      if (mem_req_o) begin
        mem_we_o   = core_we_i;
        mem_be_o   = core_we_i ? w_be : 4'b0000;
        mem_addr_o = {core_addr_i[ADDR_W-1:2], 2'b00};
        mem_wd_o   = w_wd_rep;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_lsu_v2.sv
// Randomised scoreboard bench for riscv_lsu_v2: transaction driver, arithmetic reference model, monitor.
// A second instance without alignment checking and without timeout is exercised with directed accesses.
module tb_riscv_lsu_v2;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        core_req, core_we, core_stall, core_fault;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic        nc_req, nc_ready, nc_stall, nc_fault, nc_mreq, nc_we;
  logic [3:0]  nc_be;
  logic [31:0] nc_rd, nc_addr, nc_wd;

  riscv_lsu_v2 #(.ADDR_W(32), .TIMEOUT(TO), .MISALIGN_CHECK(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .core_fault_o(core_fault),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  riscv_lsu_v2 #(.ADDR_W(32), .TIMEOUT(0), .MISALIGN_CHECK(1'b0)) u_nc (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(nc_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(nc_rd),
    .core_stall_o(nc_stall), .core_fault_o(nc_fault),
    .mem_req_o(nc_mreq), .mem_we_o(nc_we), .mem_be_o(nc_be),
    .mem_addr_o(nc_addr), .mem_wd_o(nc_wd), .mem_rd_i(mem_rd), .mem_ready_i(nc_ready)
  );

  typedef struct {
    bit          fault;
    bit          issued;
    bit          we;
    int          stalls;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   n_tot  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: what the core should observe for one access, from plain arithmetic on the access rules
  function automatic exp_t model(input bit we, input int size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdata, input int lat);
    exp_t        e;
    int          lo;
    logic [31:0] b, h;
    bit          bad;
    lo  = int'(addr[1:0]);
    bad = (size == 3) || (size >= 6) ||
          (((size == 1) || (size == 5)) && (lo % 2 != 0)) || ((size == 2) && (lo != 0));
    e.fault = bad; e.issued = !bad; e.we = we; e.stalls = 0;
    e.rd = 0; e.wd = 0; e.be = 0; e.addr = addr & 32'hFFFF_FFFC;
    if (!bad) begin
      if (lat > TO) begin e.fault = 1; e.stalls = TO; end
      else e.stalls = lat;
      b = (rdata >> (8 * lo)) & 32'hFF;
      h = (rdata >> (8 * (lo & 2))) & 32'hFFFF;
      if (we) begin
        case (size)
          0:       begin e.be = 4'(1 << lo);       e.wd = (wd & 32'hFF) * 32'h0101_0101; end
          1:       begin e.be = 4'(3 << (lo & 2)); e.wd = (wd & 32'hFFFF) * 32'h0001_0001; end
          default: begin e.be = 4'hF;              e.wd = wd; end
        endcase
      end else if (!e.fault) begin
        case (size)
          0:       e.rd = (b >= 128) ? 32'(int'(b) - 256) : b;
          4:       e.rd = b;
          1:       e.rd = (h >= 32768) ? 32'(int'(h) - 65536) : h;
          5:       e.rd = h;
          default: e.rd = rdata;
        endcase
      end
    end
    return e;
  endfunction

  // Monitor: accumulates stall cycles and the issued bus request, checks against the scoreboard on release
  int          st_cnt = 0;
  bit          seen   = 0;
  logic [31:0] o_addr, o_wd;
  logic [3:0]  o_be;
  logic        o_we;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      st_cnt = 0;
      seen   = 0;
    end else if (core_req) begin
      if (mem_req && !seen) begin
        seen = 1; o_addr = mem_addr; o_wd = mem_wd; o_be = mem_be; o_we = mem_we;
      end
      if (core_stall) begin
        st_cnt++;
        if (core_fault) chk("fault_while_stalled", 32'(core_fault), 32'd0);
      end else begin
        if (sb.size() == 0) begin
          chk("sb_empty_on_release", 32'(sb.size()), 32'd1);
        end else begin
          m_e = sb.pop_front();
          chk("fault", 32'(core_fault), 32'(m_e.fault));
          chk("rd", core_rd, m_e.rd);
          chk("stall_cycles", 32'(st_cnt), 32'(m_e.stalls));
          chk("mem_req_at_release", 32'(mem_req), 32'(!m_e.fault));
          chk("issued", 32'(seen), 32'(m_e.issued));
          if (m_e.issued && seen) begin
            chk("mem_addr", o_addr, m_e.addr);
            chk("mem_we", 32'(o_we), 32'(m_e.we));
            chk("mem_be", 32'(o_be), 32'(m_e.be));
            if (m_e.we) chk("mem_wd", o_wd, m_e.wd);
          end
        end
        st_cnt = 0;
        seen   = 0;
      end
    end else begin
      chk("idle_stall", 32'(core_stall), 32'd0);
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_fault", 32'(core_fault), 32'd0);
    end
  end

  // Issues one access at posedge+1; memory raises ready in the lat-th BUSY cycle
  task automatic access(input bit we, input int size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int lat);
    bit done;
    done = 0;
    sb.push_back(model(we, size, addr, wd, rdata, lat));
    core_req = 1; core_we = we; core_size = 3'(size); core_addr = addr;
    core_wd = wd; mem_rd = rdata; mem_ready = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      mem_ready = (k > 0) && (k == lat);
      @(negedge clk);
      done = !core_stall;
      @(posedge clk); #1;
    end
    mem_ready = 0;
    if (!done) chk("access_cycle_bound", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    core_req = 0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    mem_ready = 0;
  endtask

  int sz_tab[10] = '{0, 1, 2, 4, 5, 0, 6, 2, 3, 7};

  initial begin
    int          sz;
    bit          we, bad;
    logic [31:0] a;

    rst = 1; core_req = 1; core_we = 0; core_size = 3'd2; core_addr = 32'h100;
    core_wd = 0; mem_rd = 0; mem_ready = 0; nc_req = 1; nc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall", 32'(core_stall), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_fault", 32'(core_fault), 32'd0);
      chk("rst_rd", core_rd, 32'd0);
      chk("rst_nc_stall", 32'(nc_stall), 32'd0);
    end
    @(posedge clk); #1;
    rst = 0; core_req = 0; nc_req = 0;
    idle(2);

    access(0, 2, 32'h100, 0, 32'hDEAD_BEEF, 3);
    access(1, 0, 32'h103, 32'h0000_00A5, 0, 2);
    access(0, 0, 32'h2, 0, 32'h80F0_7F81, 1);
    access(0, 4, 32'h2, 0, 32'h80F0_7F81, 2);
    access(0, 1, 32'h2, 0, 32'h80F0_7F81, 1);
    access(0, 5, 32'h0, 0, 32'h80F0_7F81, 3);
    access(1, 1, 32'h0000_0206, 32'hCAFE_1234, 0, 1);
    access(0, 2, 32'h102, 0, 32'h1111_1111, 1);
    access(1, 1, 32'h101, 32'h5555, 0, 1);
    access(0, 3, 32'h100, 0, 32'h2222_2222, 1);
    idle(1);
    access(0, 2, 32'h104, 0, 32'h3333_3333, 5);
    idle(3);
    access(0, 2, 32'h108, 0, 32'h1234_5678, 4);
    idle(1);

    for (int n = 0; n < 300; n++) begin
      sz = sz_tab[$urandom_range(0, 9)];
      we = ((sz <= 2) || (sz == 3) || (sz >= 6)) ? 1'($urandom % 3 == 0) : 1'b0;
      a  = $urandom;
      if ($urandom % 2 == 0) a = (sz % 4 == 2) ? (a & ~32'h3) : ((sz % 4 == 1) ? (a & ~32'h1) : a);
      access(we, sz, a, $urandom, $urandom, $urandom_range(1, 6));
      if ($urandom % 2 == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // Reset in the middle of a BUSY access
    core_req = 1; core_we = 0; core_size = 3'd2; core_addr = 32'h200; mem_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_before_rst", 32'(core_stall), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_busy_stall", 32'(core_stall), 32'd0);
    chk("rst_busy_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 0; core_req = 0;
    @(negedge clk);
    chk("post_rst_mem_req", 32'(mem_req), 32'd0);
    chk("post_rst_stall", 32'(core_stall), 32'd0);
    @(posedge clk); #1;
    access(0, 4, 32'h201, 0, 32'h0000_9A00, 2);
    idle(1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Instance without alignment checking and without timeout
    core_we = 0; core_size = 3'd2; core_addr = 32'h102; mem_rd = 32'hCAFE_F00D;
    nc_req = 1; nc_ready = 0;
    @(negedge clk);
    chk("nc_mreq", 32'(nc_mreq), 32'd1);
    chk("nc_addr", nc_addr, 32'h100);
    chk("nc_stall", 32'(nc_stall), 32'd1);
    chk("nc_fault", 32'(nc_fault), 32'd0);
    @(posedge clk); #1;
    nc_ready = 1;
    @(negedge clk);
    chk("nc_release_stall", 32'(nc_stall), 32'd0);
    chk("nc_rd", nc_rd, 32'hCAFE_F00D);
    @(posedge clk); #1;
    nc_ready = 0; core_size = 3'd3; core_addr = 32'h100;
    @(negedge clk);
    chk("nc_illegal_fault", 32'(nc_fault), 32'd1);
    chk("nc_illegal_mreq", 32'(nc_mreq), 32'd0);
    chk("nc_illegal_stall", 32'(nc_stall), 32'd0);
    @(posedge clk); #1;
    core_size = 3'd2; core_addr = 32'h300;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!nc_stall || nc_fault) bad = 1;
      @(posedge clk); #1;
    end
    chk("nc_no_timeout", 32'(bad), 32'd0);
    nc_ready = 1;
    @(negedge clk);
    chk("nc_late_release", 32'(nc_stall), 32'd0);
    @(posedge clk); #1;
    nc_req = 0; nc_ready = 0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
